ddr_port_arbiter: RTL and testbench

DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

---
 rtl/ddr_arb_pkg.sv | 21 ++
 rtl/ddr_arb_tag_fifo.sv | 67 ++++++
 rtl/ddr_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ddr_arb_pkg                                                     |
// | Brief    : Shared types and constants for the two-port DDR arbiter.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DEFAULT_PEND_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/ddr_arb_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ddr_arb_tag_fifo                                                |
// | Brief    : In-order FIFO of master IDs for outstanding reads.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ddr_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ddr_port_arbiter                                                |
// | Brief    : Round-robin two-master arbiter with in-order read return.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int PEND_DEPTH = DEFAULT_PEND_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           m0_addr,
  input  logic                        m0_read,
  input  logic                        m0_write,
  input  logic [DATA_W-1:0]           m0_writedata,
  output logic                        m0_waitrequest,
  output logic [DATA_W-1:0]           m0_readdata,
  output logic                        m0_readdatavalid,
  input  logic [ADDR_W-1:0]           m1_addr,
  input  logic                        m1_read,
  input  logic                        m1_write,
  input  logic [DATA_W-1:0]           m1_writedata,
  output logic                        m1_waitrequest,
  output logic [DATA_W-1:0]           m1_readdata,
  output logic                        m1_readdatavalid,
  output logic [ADDR_W-1:0]           s_addr,
  output logic                        s_read,
  output logic                        s_write,
  output logic [DATA_W-1:0]           s_writedata,
  input  logic                        s_waitrequest,
  input  logic [DATA_W-1:0]           s_readdata,
  input  logic                        s_readdatavalid,
  output logic [$clog2(PEND_DEPTH):0] pending,
  output logic                        err_orphan
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last_grant;
  logic              w_last_grant_nxt;
  logic              r_err_orphan;

  logic              w_req0;
  logic              w_req1;
  logic              w_granted;
  logic              w_sel;
  logic              w_sel_req;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_stall;
  logic              w_accept;
  logic              w_full;
  logic              w_empty;
  logic [0:0]        w_tag;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  assign w_granted   = (r_state == GNT0) || (r_state == GNT1);
  assign w_sel       = (r_state == GNT1) ? M1 : M0;
  assign w_sel_req   = w_sel ? w_req1 : w_req0;
  assign w_sel_addr  = w_sel ? m1_addr : m0_addr;
  assign w_sel_wdata = w_sel ? m1_writedata : m0_writedata;
  // Read wins when a master raises read and write together.
  assign w_sel_rd    = w_sel ? m1_read : m0_read;
  assign w_sel_wr    = w_sel ? (m1_write & ~m1_read) : (m0_write & ~m0_read);

  assign w_stall     = w_granted & w_sel_rd & w_full;
  assign s_read      = w_granted & w_sel_rd & ~w_full;
  assign s_write     = w_granted & w_sel_wr;
  assign s_addr      = w_granted ? w_sel_addr : '0;
  assign s_writedata = w_granted ? w_sel_wdata : '0;
  assign w_accept    = (s_read | s_write) & ~s_waitrequest;

  assign m0_waitrequest = (r_state != GNT0) | s_waitrequest | w_stall;
  assign m1_waitrequest = (r_state != GNT1) | s_waitrequest | w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= M1;
      r_err_orphan <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err_orphan <= r_err_orphan | (s_readdatavalid & w_empty);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_nxt = (r_last_grant == M1) ? GNT0 : GNT1;
        end else if (w_req0) begin
          w_state_nxt = GNT0;
        end else if (w_req1) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        // A withdrawn request releases the grant without counting as a turn.
        if (!w_sel_req) begin
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = w_sel;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  ddr_arb_tag_fifo #(
    .DEPTH (PEND_DEPTH),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept & s_read),
    .pop   (s_readdatavalid),
    .din   (w_sel),
    .dout  (w_tag),
    .full  (w_full),
    .empty (w_empty),
    .count (pending)
  );

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = s_readdatavalid & ~w_empty & (w_tag == M0);
  assign m1_readdatavalid = s_readdatavalid & ~w_empty & (w_tag == M1);
  assign err_orphan       = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ddr_port_arbiter                                             |
// | Brief    : Scoreboard bench for ddr_port_arbiter.                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ddr_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 16;
  localparam int PEND_DEPTH = 4;
  localparam int CNT_W      = $clog2(PEND_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [CNT_W-1:0]  pending;
  logic              err_orphan;

  ddr_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_DEPTH(PEND_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_addr(s_addr), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .pending(pending), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          orphan;
    int          id;
    logic [15:0] data;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  int          ref_tags[$];   // master IDs of accepted reads, oldest first
  rsp_t        exp_q[$];      // expected effect of each slave response issued
  int          acc_log[$];
  logic [15:0] rcv0[$], rcv1[$];
  bit          orphan_model = 1'b0;
  bit          done0, done1;
  rsp_t        e;
  int          sz;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  function automatic logic f_wait(input int id);
    return (id == 0) ? m0_waitrequest : m1_waitrequest;
  endfunction
  function automatic logic f_rd(input int id);
    return (id == 0) ? m0_read : m1_read;
  endfunction
  function automatic logic f_wr(input int id);
    return (id == 0) ? m0_write : m1_write;
  endfunction
  function automatic logic [31:0] f_addr(input int id);
    return (id == 0) ? m0_addr : m1_addr;
  endfunction
  function automatic logic [15:0] f_wd(input int id);
    return (id == 0) ? m0_writedata : m1_writedata;
  endfunction

  task automatic set_req(input int id, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [15:0] d);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_addr = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_addr = a; m1_writedata = d;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance cycle.
  task automatic issue(input int id, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [15:0] d, output int w);
    set_req(id, rd, wr, a, d);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (f_wait(id) && w < 300);
    if (f_wait(id)) chk("req_timeout", 64'(w), 64'(0));
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic master_run(input int id, input int n, input bit wr_only,
                            input int gap, output int maxw);
    int g, w;
    logic rd, wr;
    logic [31:0] a;
    logic [15:0] d;
    maxw = 0;
    for (int k = 0; k < n; k++) begin
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      rd = wr_only ? 1'b0 : 1'($urandom_range(1, 0));
      wr = !rd || ($urandom_range(7, 0) == 0);
      a  = $urandom;
      d  = 16'($urandom);
      issue(id, rd, wr, a, d, w);
      if (w > maxw) maxw = w;
    end
  endtask

  // Expected owner follows acceptance order; no outstanding read means orphan.
  task automatic drive_rsp(input logic [15:0] d);
    rsp_t r;
    r.data   = d;
    r.orphan = (ref_tags.size() == 0);
    r.id     = r.orphan ? -1 : ref_tags[0];
    exp_q.push_back(r);
    s_readdatavalid = 1'b1;
    s_readdata      = d;
  endtask

  task automatic slave_respond(input logic [15:0] d);
    drive_rsp(d);
    @(posedge clk); #1;
    s_readdatavalid = 1'b0;
  endtask

  task automatic slave_random();
    int cyc = 0;
    while (!(done0 && done1 && ref_tags.size() == 0) && cyc < 6000) begin
      s_waitrequest = ($urandom_range(2, 0) == 0);
      if (ref_tags.size() > 0 && $urandom_range(2, 0) == 0) drive_rsp(16'($urandom));
      else s_readdatavalid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    s_readdatavalid = 1'b0;
    s_waitrequest   = 1'b0;
    if (cyc >= 6000) chk("drain_timeout", 64'(cyc), 64'(0));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    ref_tags.delete();
    exp_q.delete();
    orphan_model = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    s_readdatavalid = 1'b0;
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  // Monitor: registered status reflects events up to the previous cycle, so
  // compare before folding in this cycle's responses and acceptances.
  always @(negedge clk) begin
    if (!reset) begin
      sz = ref_tags.size();
      chk("pending", 64'(pending), 64'(sz));
      chk("err_orphan", 64'(err_orphan), 64'(orphan_model));
      chk("wait_excl", 64'(!m0_waitrequest && !m1_waitrequest), 64'(0));
      if (sz == PEND_DEPTH) chk("full_stall_s_read", 64'(s_read), 64'(0));
      if (s_readdatavalid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          if (e.orphan) begin
            chk("orphan_rdv0", 64'(m0_readdatavalid), 64'(0));
            chk("orphan_rdv1", 64'(m1_readdatavalid), 64'(0));
            orphan_model = 1'b1;
          end else begin
            chk("rdv_m0", 64'(m0_readdatavalid), 64'(e.id == 0));
            chk("rdv_m1", 64'(m1_readdatavalid), 64'(e.id == 1));
            chk("rdata_m0", 64'(m0_readdata), 64'(e.data));
            chk("rdata_m1", 64'(m1_readdata), 64'(e.data));
            void'(ref_tags.pop_front());
            if (m0_readdatavalid) rcv0.push_back(m0_readdata);
            if (m1_readdatavalid) rcv1.push_back(m1_readdata);
          end
        end
      end else begin
        chk("idle_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
      end
      for (int i = 0; i < 2; i++) begin
        if ((f_rd(i) || f_wr(i)) && !f_wait(i)) begin
          chk("acc_addr", 64'(s_addr), 64'(f_addr(i)));
          chk("acc_read", 64'(s_read), 64'(f_rd(i)));
          chk("acc_write", 64'(s_write), 64'(f_wr(i) && !f_rd(i)));
          chk("acc_wdata", 64'(s_writedata), 64'(f_wd(i)));
          if (f_rd(i)) ref_tags.push_back(i);
          acc_log.push_back(i);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int w, mw0, mw1;
    logic [15:0] x0 [3];
    logic [15:0] x1 [2];
    x0 = '{16'hA, 16'hC, 16'hE};
    x1 = '{16'hB, 16'hD};

    do_reset(3);
    @(negedge clk);
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_err", 64'(err_orphan), 64'(0));
    chk("rst_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b11));
    chk("rst_s_cmd", 64'({s_read, s_write}), 64'(0));
    @(posedge clk); #1;

    // Single write from m0 with a ready slave
    set_req(0, 1'b0, 1'b1, 32'h10, 16'h1234);
    @(negedge clk);
    chk("idle_s_write", 64'(s_write), 64'(0));
    @(negedge clk);
    chk("wr_s_write", 64'(s_write), 64'(1));
    chk("wr_s_addr", 64'(s_addr), 64'(32'h10));
    chk("wr_s_wdata", 64'(s_writedata), 64'(16'h1234));
    chk("wr_m0_wait", 64'(m0_waitrequest), 64'(0));
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("wr_back_idle", 64'({s_write, m0_waitrequest}), 64'(2'b01));
    @(posedge clk); #1;

    // Continuous writes from both masters right after reset: m0 wins the tie
    do_reset(2);
    acc_log.delete();
    fork
      master_run(0, 4, 1'b1, 0, mw0);
      master_run(1, 4, 1'b1, 0, mw1);
    join
    chk("rr_count", 64'(acc_log.size()), 64'(8));
    if (acc_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("rr_order", 64'(acc_log[i]), 64'(i % 2));
    chk("rr_wait_m0", 64'(mw0 <= 4), 64'(1));
    chk("rr_wait_m1", 64'(mw1 <= 4), 64'(1));

    // m1 read held off by the slave for three granted cycles
    rcv1.delete();
    s_waitrequest = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h40, '0);
    @(negedge clk);
    chk("ws_idle_m1", 64'(m1_waitrequest), 64'(1));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("ws_m1_wait", 64'(m1_waitrequest), 64'(1));
      chk("ws_m0_wait", 64'(m0_waitrequest), 64'(1));
      chk("ws_s_read", 64'(s_read), 64'(1));
    end
    @(posedge clk); #1;
    s_waitrequest = 1'b0;
    @(negedge clk);
    chk("ws_accept", 64'({m1_waitrequest, m0_waitrequest}), 64'(2'b01));
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    slave_respond(16'h0B0B);
    chk("ws_rsp", 64'(rcv1.size() == 1 && rcv1[0] == 16'h0B0B), 64'(1));

    // Four interleaved reads fill the tag FIFO; a fifth must wait
    rcv0.delete(); rcv1.delete();
    issue(0, 1'b1, 1'b0, 32'h100, '0, w);
    issue(1, 1'b1, 1'b0, 32'h104, '0, w);
    issue(0, 1'b1, 1'b0, 32'h108, '0, w);
    issue(1, 1'b1, 1'b0, 32'h10C, '0, w);
    @(negedge clk);
    chk("peak_pending", 64'(pending), 64'(4));
    @(posedge clk); #1;
    fork
      issue(0, 1'b1, 1'b0, 32'h110, '0, w);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_m0_wait", 64'(m0_waitrequest), 64'(1));
          chk("stall_s_read", 64'(s_read), 64'(0));
        end
        @(posedge clk); #1;
        slave_respond(16'hA);
        slave_respond(16'hB);
        slave_respond(16'hC);
        slave_respond(16'hD);
      end
    join
    slave_respond(16'hE);
    chk("rcv0_n", 64'(rcv0.size()), 64'(3));
    chk("rcv1_n", 64'(rcv1.size()), 64'(2));
    if (rcv0.size() == 3) for (int i = 0; i < 3; i++) chk("rcv0_data", 64'(rcv0[i]), 64'(x0[i]));
    if (rcv1.size() == 2) for (int i = 0; i < 2; i++) chk("rcv1_data", 64'(rcv1[i]), 64'(x1[i]));

    // Response with nothing outstanding
    slave_respond(16'h77);
    repeat (3) @(negedge clk);
    chk("orphan_held", 64'(err_orphan), 64'(1));
    @(posedge clk); #1;

    // Reset with two reads outstanding; their late responses become orphans
    issue(0, 1'b1, 1'b0, 32'h200, '0, w);
    issue(1, 1'b1, 1'b0, 32'h204, '0, w);
    @(negedge clk);
    chk("pre_rst_pending", 64'(pending), 64'(2));
    @(posedge clk); #1;
    do_reset(1);
    @(negedge clk);
    chk("mid_rst_pending", 64'(pending), 64'(0));
    chk("mid_rst_err", 64'(err_orphan), 64'(0));
    chk("mid_rst_idle", 64'({m0_waitrequest, m1_waitrequest}), 64'(2'b11));
    @(posedge clk); #1;
    slave_respond(16'h1);
    slave_respond(16'h2);
    @(negedge clk);
    chk("post_rst_orphan", 64'(err_orphan), 64'(1));
    @(posedge clk); #1;

    // Randomised traffic from both masters against a randomly stalling slave
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin master_run(0, 40, 1'b0, 3, mw0); done0 = 1'b1; end
      begin master_run(1, 40, 1'b0, 3, mw1); done1 = 1'b1; end
      slave_random();
    join
    repeat (2) @(posedge clk);
    chk("drain_tags", 64'(ref_tags.size()), 64'(0));
    chk("drain_exp", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
